fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle core: owns the architectural PC register, issues one request per instruction to instruction memory over a req/ack handshake, and holds the fetched word for decode until the core accepts it. On acceptance it loads the next-PC value produced by the next-PC logic, which consumes this block's `pc` output. It also detects misaligned next-PC targets and instruction-memory timeouts, and counts retired instructions.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, decode handoff and status.
// master = fetch_unit side, slave = memory/core side.
interface fetch_unit_if;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  modport master (
    input  npc, imem_ack, imem_rdata, instr_ready,
    output pc, imem_req, imem_addr, instr, instr_valid, fault, fault_code, retired
  );

  modport slave (
    output npc, imem_ack, imem_rdata, instr_ready,
    input  pc, imem_req, imem_addr, instr, instr_valid, fault, fault_code, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over req/ack,
// holds it for decode, and traps misaligned next-PC targets and memory timeouts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

  // Last legal wait-counter value before a missing ack becomes a fault.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [1:0]  fault_code_q;
  logic [15:0] wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      retired_q    <= 32'h0;
      fault_code_q <= 2'b00;
      wait_q       <= 16'h0;
    end else begin
      unique case (state_q)
        StFetch: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            wait_q  <= 16'h0;
            state_q <= StHold;
          end else if (wait_q == WaitLast) begin
            fault_code_q <= 2'b10;
            state_q      <= StFault;
          end else begin
            wait_q <= wait_q + 16'h1;
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            if (bus.npc[1:0] == 2'b00) begin
              pc_q      <= bus.npc;
              retired_q <= retired_q + 32'h1;
              state_q   <= StFetch;
            end else begin
              fault_code_q <= 2'b01;
              state_q      <= StFault;
            end
          end
        end
        StFault: state_q <= StFault;
        default: state_q <= StFault;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = (state_q == StFetch);
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == StHold);
  assign bus.fault       = (state_q == StFault);
  assign bus.fault_code  = fault_code_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against an abstract fetch model.
module tb_fetch_unit;

  localparam int TO_A = 16;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );
  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  // Abstract model: "are we waiting on memory, holding a word, or dead".
  logic [31:0] m_pc, m_instr, m_retired;
  logic [1:0]  m_code;
  bit          m_faulted, m_holding;
  int          m_waited;

  task automatic model_step(input logic r, input logic ack, input logic [31:0] rdata,
                            input logic ready, input logic [31:0] npc);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0; m_code = 2'b00;
      m_faulted = 1'b0; m_holding = 1'b0; m_waited = 0;
    end else if (m_faulted) begin
      // dead until reset
    end else if (m_holding) begin
      if (ready) begin
        if (npc % 4 == 0) begin
          m_pc = npc; m_retired = m_retired + 1; m_holding = 1'b0; m_waited = 0;
        end else begin
          m_faulted = 1'b1; m_code = 2'b01;
        end
      end
    end else if (ack) begin
      m_instr = rdata; m_holding = 1'b1;
    end else begin
      m_waited++;
      if (m_waited == TO_A) begin
        m_faulted = 1'b1; m_code = 2'b10;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic ack, input logic [31:0] rdata,
                         input logic ready, input logic [31:0] npc);
    rst_a = r; ifa.imem_ack = ack; ifa.imem_rdata = rdata;
    ifa.instr_ready = ready; ifa.npc = npc;
    @(posedge clk);
    model_step(r, ack, rdata, ready, npc);
    @(negedge clk);
  endtask

  task automatic drive_b(input logic r, input logic ack, input logic [31:0] rdata);
    rst_b = r; ifb.imem_ack = ack; ifb.imem_rdata = rdata;
    ifb.instr_ready = 1'b0; ifb.npc = 32'h0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, ifa.pc, m_pc);
    check({tag, ".addr"}, ifa.imem_addr, m_pc);
    check({tag, ".req"}, 32'(ifa.imem_req), 32'(!m_faulted && !m_holding));
    check({tag, ".valid"}, 32'(ifa.instr_valid), 32'(m_holding && !m_faulted));
    check({tag, ".instr"}, ifa.instr, m_instr);
    check({tag, ".fault"}, 32'(ifa.fault), 32'(m_faulted));
    check({tag, ".code"}, 32'(ifa.fault_code), 32'(m_code));
    check({tag, ".retired"}, ifa.retired, m_retired);
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] retired;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cycles;
    logic [31:0] npc_r;
    logic r, ack, ready;

    // Reset, zero-wait fetch, consume, backpressure, misaligned npc, reset in FAULT.
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'h2008_0005, 1'b0, 32'h0,
                 32'h0, 1'b0, 1'b1, 32'h2008_0005, 1'b0, 2'b00, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4,
                 32'h4, 1'b1, 1'b0, 32'h2008_0005, 1'b0, 2'b00, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'h4, 1'b1, 1'b0, 32'h2008_0005, 1'b0, 2'b00, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0,
                 32'h4, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 2'b00, 32'd1};
    for (int i = 5; i <= 8; i++)
      vecs[i] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h8,
                  32'h4, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 2'b00, 32'd1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8,
                 32'h8, 1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 2'b00, 32'd2};
    vecs[10] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,
                 32'h8, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 32'd2};
    vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102,
                 32'h8, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 2'b01, 32'd2};
    vecs[12] = '{1'b0, 1'b1, 32'h5555_5555, 1'b1, 32'h10,
                 32'h8, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 2'b01, 32'd2};
    vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'd0};

    ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'h0; ifa.instr_ready = 1'b0; ifa.npc = 32'h0;
    ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'h0; ifb.instr_ready = 1'b0; ifb.npc = 32'h0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive_a(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].npc);
      check($sformatf("vec%0d.pc", i), ifa.pc, vecs[i].pc);
      check($sformatf("vec%0d.addr", i), ifa.imem_addr, vecs[i].pc);
      check($sformatf("vec%0d.req", i), 32'(ifa.imem_req), 32'(vecs[i].req));
      check($sformatf("vec%0d.valid", i), 32'(ifa.instr_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.instr", i), ifa.instr, vecs[i].instr);
      check($sformatf("vec%0d.fault", i), 32'(ifa.fault), 32'(vecs[i].fault));
      check($sformatf("vec%0d.code", i), 32'(ifa.fault_code), 32'(vecs[i].code));
      check($sformatf("vec%0d.retired", i), ifa.retired, vecs[i].retired);
    end

    // Memory ack delayed 5 cycles: request held 6 cycles at a constant address.
    drive_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifa.imem_req) req_cycles++;
      drive_a(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);
      check("slow.addr", ifa.imem_addr, 32'h0);
      check("slow.fault", 32'(ifa.fault), 32'h0);
    end
    if (ifa.imem_req) req_cycles++;
    drive_a(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0);
    check("slow.req_cycles", req_cycles, 6);
    check("slow.valid", 32'(ifa.instr_valid), 32'h1);
    check("slow.instr", ifa.instr, 32'h0BAD_F00D);
    check("slow.req_low", 32'(ifa.imem_req), 32'h0);

    // Reset asserted mid-FETCH.
    drive_a(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    check("midrst.pc_before", ifa.pc, 32'h40);
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_model("midrst");
    check("midrst.pc", ifa.pc, 32'h0);
    check("midrst.retired", ifa.retired, 32'h0);
    drive_a(1'b0, 1'b1, 32'h7777_0000, 1'b0, 32'h0);
    check("midrst.refetch", ifa.instr, 32'h7777_0000);

    // TIMEOUT=4: no ack faults after 4 request cycles; ack on the 4th does not.
    drive_b(1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      drive_b(1'b0, 1'b0, 32'h0);
      check($sformatf("to%0d.req", i), 32'(ifb.imem_req), 32'h1);
      check($sformatf("to%0d.fault", i), 32'(ifb.fault), 32'h0);
    end
    drive_b(1'b0, 1'b0, 32'h0);
    check("to4.fault", 32'(ifb.fault), 32'h1);
    check("to4.code", 32'(ifb.fault_code), 32'h2);
    check("to4.req", 32'(ifb.imem_req), 32'h0);
    drive_b(1'b0, 1'b1, 32'h1111_1111);
    check("to_ack_ignored.valid", 32'(ifb.instr_valid), 32'h0);
    check("to_ack_ignored.instr", ifb.instr, 32'h0);
    drive_b(1'b1, 1'b0, 32'h0);
    check("to_rst.fault", 32'(ifb.fault), 32'h0);
    check("to_rst.code", 32'(ifb.fault_code), 32'h0);
    check("to_rst.req", 32'(ifb.imem_req), 32'h1);
    for (int i = 0; i < 3; i++) drive_b(1'b0, 1'b0, 32'h0);
    drive_b(1'b0, 1'b1, 32'hCAFE_F00D);
    check("to_last_ack.valid", 32'(ifb.instr_valid), 32'h1);
    check("to_last_ack.fault", 32'(ifb.fault), 32'h0);
    check("to_last_ack.instr", ifb.instr, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    drive_a(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, m_faulted ? 20 : 400) == 0);
      ack = ($urandom_range(0, 9) < 3);
      ready = 1'($urandom_range(0, 1));
      npc_r = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 59) == 0) npc_r[1:0] = 2'($urandom_range(1, 3));
      drive_a(r, ack, $urandom, ready, npc_r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
